pulse_train_generator: RTL and testbench

PULSE_TRAIN_GENERATOR -- requirements
Module: pulse_train_generator

---
 rtl/pulse_gen_pkg.sv | 19 +
 rtl/pulse_down_counter.sv | 36 +++
 rtl/pulse_train_generator.sv | 172 +++++++++++++++++
 tb/tb_pulse_train_generator.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_gen_pkg.sv
// Shared types for the pulse train generator: FSM state encoding and timing helpers.
package pulse_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    HIGH  = 2'd2,
    LOW   = 2'd3
  } state_t;

  // Widest timing value the helpers accept; narrower counters are zero-extended into it.
  typedef logic [63:0] wide_cnt_t;

  // A train needs at least one high cycle and at least one low cycle per period.
  function automatic logic cfg_legal(wide_cnt_t width, wide_cnt_t period);
    return (width != '0) && (period > width);
  endfunction

endpackage

// File: rtl/pulse_down_counter.sv
// Loadable down-counter used to time the DELAY, HIGH and LOW phases; holds at zero.
module pulse_down_counter import pulse_gen_pkg::*; #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             enable,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (enable && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/pulse_train_generator.sv
// Programmable pulse train generator: optional start delay, then N (or endless) pulses of
// W high cycles repeating every P cycles, with abort, config checking and status strobes.
module pulse_train_generator import pulse_gen_pkg::*; #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned REP_W       = 16,
  parameter bit          ACTIVE_HIGH = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] cfg_delay,
  input  logic [CNT_W-1:0] cfg_width,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [REP_W-1:0] cfg_count,
  output logic             pulse_out,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  output logic             delay_led,
  output logic             pulse_led
);

  state_t state_q, state_d;

  logic [CNT_W-1:0] width_q;
  logic [CNT_W-1:0] low_q;
  logic [REP_W-1:0] count_q;
  logic [REP_W-1:0] pulse_cnt_q, pulse_cnt_d;

  logic             pulse_q, done_q, done_d, cfg_err_q, cfg_err_d;
  logic             accept;
  logic             legal;
  logic             last_pulse;

  logic             cnt_load, cnt_en, cnt_zero;
  logic [CNT_W-1:0] cnt_load_val;
  logic [CNT_W-1:0] cnt_value;

  pulse_down_counter #(
    .CNT_W (CNT_W)
  ) u_phase_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .enable   (cnt_en),
    .load_val (cnt_load_val),
    .count    (cnt_value),
    .zero     (cnt_zero)
  );

  assign legal = cfg_legal(wide_cnt_t'(cfg_width), wide_cnt_t'(cfg_period));

  // pulse_cnt_q counts completed HIGH phases; count_q == 0 means run until abort.
  assign last_pulse = (count_q != '0) && (pulse_cnt_q == count_q - REP_W'(1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and phase-counter control
  always_comb begin
    state_d      = state_q;
    cnt_load     = 1'b0;
    cnt_en       = 1'b0;
    cnt_load_val = '0;
    pulse_cnt_d  = pulse_cnt_q;
    done_d       = 1'b0;
    cfg_err_d    = 1'b0;
    accept       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          if (legal) begin
            accept      = 1'b1;
            cnt_load    = 1'b1;
            pulse_cnt_d = '0;
            if (cfg_delay == '0) begin
              state_d      = HIGH;
              cnt_load_val = cfg_width - CNT_W'(1);
            end else begin
              state_d      = DELAY;
              cnt_load_val = cfg_delay - CNT_W'(1);
            end
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      DELAY: begin
        cnt_en = 1'b1;
        if (cnt_zero) begin
          state_d      = HIGH;
          cnt_load     = 1'b1;
          cnt_load_val = width_q - CNT_W'(1);
        end
      end
      HIGH: begin
        cnt_en = 1'b1;
        if (cnt_zero) begin
          if (last_pulse) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d      = LOW;
            cnt_load     = 1'b1;
            cnt_load_val = low_q;
          end
          // Saturate so continuous trains never wrap the counter.
          if (pulse_cnt_q != '1) begin
            pulse_cnt_d = pulse_cnt_q + REP_W'(1);
          end
        end
      end
      LOW: begin
        cnt_en = 1'b1;
        if (cnt_zero) begin
          state_d      = HIGH;
          cnt_load     = 1'b1;
          cnt_load_val = width_q - CNT_W'(1);
        end
      end
    endcase

    if (abort && (state_q != IDLE)) begin
      state_d  = IDLE;
      done_d   = 1'b0;
      cnt_load = 1'b0;
    end
  end

  // Latched configuration, pulse counter and registered strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      width_q     <= '0;
      low_q       <= '0;
      count_q     <= '0;
      pulse_cnt_q <= '0;
      pulse_q     <= ~ACTIVE_HIGH;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      if (accept) begin
        width_q <= cfg_width;
        low_q   <= cfg_period - cfg_width - CNT_W'(1);
        count_q <= cfg_count;
      end
      pulse_cnt_q <= pulse_cnt_d;
      // Driven from the next state so the output flop tracks HIGH exactly.
      pulse_q     <= ((state_d == HIGH) == ACTIVE_HIGH);
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  // Outputs
  always_comb begin
    busy      = (state_q != IDLE);
    delay_led = (state_q == DELAY);
    pulse_led = (state_q == HIGH);
    pulse_out = pulse_q;
    done      = done_q;
    cfg_err   = cfg_err_q;
  end

endmodule

// File: tb/tb_pulse_train_generator.sv
// Self-checking bench: randomized trains checked cycle by cycle against an arithmetic model.
module tb_pulse_train_generator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, abort;
  logic [31:0] cfg_delay, cfg_width, cfg_period;
  logic [15:0] cfg_count;
  logic        pulse_out, busy, done, cfg_err, delay_led, pulse_led;

  logic        start2, abort2;
  logic [7:0]  cfg_delay2, cfg_width2, cfg_period2;
  logic [3:0]  cfg_count2;
  logic        pulse_out2, busy2, done2, cfg_err2, delay_led2, pulse_led2;

  logic [5:0]  obs1, obs2;
  assign obs1 = {pulse_out, busy, done, cfg_err, delay_led, pulse_led};
  assign obs2 = {pulse_out2, busy2, done2, cfg_err2, delay_led2, pulse_led2};

  int n_cmp;
  int n_err;

  pulse_train_generator dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .cfg_delay  (cfg_delay),
    .cfg_width  (cfg_width),
    .cfg_period (cfg_period),
    .cfg_count  (cfg_count),
    .pulse_out  (pulse_out),
    .busy       (busy),
    .done       (done),
    .cfg_err    (cfg_err),
    .delay_led  (delay_led),
    .pulse_led  (pulse_led)
  );

  pulse_train_generator #(
    .CNT_W       (8),
    .REP_W       (4),
    .ACTIVE_HIGH (1'b0)
  ) dut2 (
    .clk        (clk),
    .reset      (reset),
    .start      (start2),
    .abort      (abort2),
    .cfg_delay  (cfg_delay2),
    .cfg_width  (cfg_width2),
    .cfg_period (cfg_period2),
    .cfg_count  (cfg_count2),
    .pulse_out  (pulse_out2),
    .busy       (busy2),
    .done       (done2),
    .cfg_err    (cfg_err2),
    .delay_led  (delay_led2),
    .pulse_led  (pulse_led2)
  );

  // Reference model: t is measured in cycles from the start cycle (start high at t = 0).
  function automatic longint m_last(longint d, longint w, longint p, longint n);
    return d + (n - 1) * p + w;
  endfunction

  function automatic logic m_high(longint t, longint d, longint w, longint p, longint n);
    longint k;
    if (t < d + 1) return 1'b0;
    k = t - d - 1;
    if (n != 0 && (k / p) >= n) return 1'b0;
    return (k % p) < w;
  endfunction

  function automatic logic [5:0] m_vec(longint t, longint d, longint w, longint p, longint n);
    logic hi, bz, dn, dl;
    hi = m_high(t, d, w, p, n);
    bz = (t >= 1) && (n == 0 || t <= m_last(d, w, p, n));
    dn = (n != 0) && (t == m_last(d, w, p, n) + 1);
    dl = (t >= 1) && (t <= d);
    return {hi, bz, dn, 1'b0, dl, hi};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(longint d, longint w, longint p, longint n);
    cfg_delay  = 32'(d);
    cfg_width  = 32'(w);
    cfg_period = 32'(p);
    cfg_count  = 16'(n);
  endtask

  task automatic test_reset();
    for (int t = 0; t < 4; t++) begin
      step();
      reset  = (t < 3);
      start  = 1'b1;
      start2 = 1'b1;
      set_cfg(0, 1, 2, 1);
      @(negedge clk);
      n_cmp++;
      if (obs1 !== 6'b000000) begin
        n_err++;
        $display("FAIL reset t=%0d got %b exp %b", t, obs1, 6'b000000);
      end
      n_cmp++;
      if (obs2 !== 6'b100000) begin
        n_err++;
        $display("FAIL reset_inv t=%0d got %b exp %b", t, obs2, 6'b100000);
      end
    end
    start  = 1'b0;
    start2 = 1'b0;
  endtask

  // D=3 W=2 P=5 N=3 plus a held-config train with mid-train cfg changes and starts.
  task automatic test_directed();
    logic [5:0] exp;
    for (longint t = 0; t <= 20; t++) begin
      step();
      start = (t == 0);
      if (t == 0) set_cfg(3, 2, 5, 3);
      @(negedge clk);
      exp = m_vec(t, 3, 2, 5, 3);
      n_cmp++;
      if (obs1 !== exp) begin
        n_err++;
        $display("FAIL basic t=%0d got %b exp %b", t, obs1, exp);
      end
    end
    for (longint t = 0; t <= 14; t++) begin
      step();
      start = (t == 0) || (t == 4) || (t == 11);
      if (t == 0) set_cfg(2, 3, 6, 2);
      if (t == 4) set_cfg(0, 1, 2, 0);
      @(negedge clk);
      exp = m_vec(t, 2, 3, 6, 2);
      n_cmp++;
      if (obs1 !== exp) begin
        n_err++;
        $display("FAIL cfg_hold t=%0d got %b exp %b", t, obs1, exp);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_random_trains();
    longint d, w, p, n, last;
    logic [5:0] exp;
    for (int it = 0; it < 10; it++) begin
      d    = $urandom_range(0, 6);
      w    = $urandom_range(1, 5);
      p    = w + $urandom_range(1, 6);
      n    = $urandom_range(1, 4);
      last = m_last(d, w, p, n);
      for (longint t = 0; t <= last + 2; t++) begin
        step();
        if (t == 0) begin
          set_cfg(d, w, p, n);
          start = 1'b1;
        end else begin
          // Junk starts and config churn while busy must not disturb the train.
          start = (t <= last) && ($urandom_range(0, 2) == 0);
          set_cfg($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9),
                  $urandom_range(0, 5));
        end
        @(negedge clk);
        exp = m_vec(t, d, w, p, n);
        n_cmp++;
        if (obs1 !== exp) begin
          n_err++;
          $display("FAIL random_train it=%0d t=%0d got %b exp %b", it, t, obs1, exp);
        end
      end
    end
    start = 1'b0;
  endtask

  task automatic test_abort();
    longint d, w, p, n, a;
    logic [5:0] exp;
    for (int it = 0; it < 7; it++) begin
      if (it == 0) begin
        d = 0; w = 1; p = 2; n = 0; a = 10;
      end else begin
        d = $urandom_range(0, 4);
        w = $urandom_range(1, 3);
        p = w + $urandom_range(1, 3);
        n = $urandom_range(0, 3);
        a = $urandom_range(1, (n == 0) ? 30 : 32'(m_last(d, w, p, n)));
      end
      for (longint t = 0; t <= a + 3; t++) begin
        step();
        start = (t == 0);
        abort = (t == a);
        if (t == 0) set_cfg(d, w, p, n);
        @(negedge clk);
        exp = (t <= a) ? m_vec(t, d, w, p, n) : 6'b000000;
        n_cmp++;
        if (obs1 !== exp) begin
          n_err++;
          $display("FAIL abort it=%0d t=%0d got %b exp %b", it, t, obs1, exp);
        end
      end
    end
    abort = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_cfg_err();
    longint ws[4] = '{4, 0, 3, 1};
    longint ps[4] = '{4, 5, 1, 2};
    logic [5:0] exp;
    for (int i = 0; i < 4; i++) begin
      for (int t = 0; t < 4; t++) begin
        step();
        start = (t == 0);
        abort = (i == 3) && (t == 0);  // last case: legal config, but abort wins
        set_cfg(0, ws[i], ps[i], 1);
        @(negedge clk);
        exp = (i != 3 && t == 1) ? 6'b000100 : 6'b000000;
        n_cmp++;
        if (obs1 !== exp) begin
          n_err++;
          $display("FAIL cfg_err case=%0d t=%0d got %b exp %b", i, t, obs1, exp);
        end
      end
    end
    abort = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp;
    for (longint t = 0; t <= 12; t++) begin
      step();
      start = (t == 0) || (t == 6);
      if (t == 0) set_cfg(1, 1, 3, 2);
      if (t == 6) set_cfg(0, 2, 3, 1);
      @(negedge clk);
      exp = m_vec(t, 1, 1, 3, 2) | m_vec(t - 6, 0, 2, 3, 1);
      n_cmp++;
      if (obs1 !== exp) begin
        n_err++;
        $display("FAIL back_to_back t=%0d got %b exp %b", t, obs1, exp);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset_mid();
    longint r;
    logic [5:0] exp;
    for (int it = 0; it < 3; it++) begin
      r = 3 + 6 * $urandom_range(0, 4) + $urandom_range(0, 2);  // inside a HIGH phase
      for (longint t = 0; t <= r + 1 + m_last(1, 2, 4, 2) + 2; t++) begin
        step();
        reset = (t == r);
        start = (t == 0) || (t == r + 1);
        if (t == 0) set_cfg(2, 3, 6, 5);
        if (t == r + 1) set_cfg(1, 2, 4, 2);
        @(negedge clk);
        exp = (t <= r) ? m_vec(t, 2, 3, 6, 5) : m_vec(t - r - 1, 1, 2, 4, 2);
        n_cmp++;
        if (obs1 !== exp) begin
          n_err++;
          $display("FAIL reset_mid it=%0d t=%0d got %b exp %b", it, t, obs1, exp);
        end
      end
    end
    reset = 1'b0;
    start = 1'b0;
  endtask

  // Inverted polarity and narrow-counter limits on the second instance.
  task automatic test_inverted();
    longint ds[4] = '{1, 0, 255, 3};
    longint ws[4] = '{2, 1, 254, 1};
    longint ps[4] = '{3, 2, 255, 2};
    longint ns[4] = '{1, 15, 1, 0};
    longint lim;
    logic [5:0] exp;
    for (int i = 0; i < 4; i++) begin
      lim = (ns[i] == 0) ? 43 : m_last(ds[i], ws[i], ps[i], ns[i]) + 2;
      for (longint t = 0; t <= lim; t++) begin
        step();
        start2      = (t == 0);
        abort2      = (ns[i] == 0) && (t == 40);
        cfg_delay2  = 8'(ds[i]);
        cfg_width2  = 8'(ws[i]);
        cfg_period2 = 8'(ps[i]);
        cfg_count2  = 4'(ns[i]);
        @(negedge clk);
        exp = (ns[i] == 0 && t > 40) ? 6'b000000 : m_vec(t, ds[i], ws[i], ps[i], ns[i]);
        exp = exp ^ 6'b100000;
        n_cmp++;
        if (obs2 !== exp) begin
          n_err++;
          $display("FAIL inverted case=%0d t=%0d got %b exp %b", i, t, obs2, exp);
        end
      end
    end
    abort2 = 1'b0;
    start2 = 1'b0;
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    reset  = 1'b1;
    start  = 1'b0;
    abort  = 1'b0;
    start2 = 1'b0;
    abort2 = 1'b0;
    set_cfg(0, 1, 2, 1);
    cfg_delay2  = '0;
    cfg_width2  = 8'd1;
    cfg_period2 = 8'd2;
    cfg_count2  = 4'd1;

    test_reset();
    test_directed();
    test_random_trains();
    test_abort();
    test_cfg_err();
    test_back_to_back();
    test_reset_mid();
    test_inverted();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
